// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock-qualify/release sequencer (clk_25MHz, async rst; pll_locked, fault_clear in; pll_rst, sys_rst, ready, fault, relock_count out)
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       fault_clear,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count
);
  typedef enum logic [2:0] {PLLRST, WAITLOCK, STABLE, RUN, FAULT} state_t;
  localparam logic [15:0] RST_END    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_END   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_END = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  MAX_R      = 4'(MAX_RETRIES);
  state_t      state, nxt;
  logic        sync1, lock_s;
  logic [15:0] cnt;
  logic [3:0]  retries, retries_nxt;
  logic [7:0]  relock_nxt;
  always_comb begin
    nxt         = state;
    retries_nxt = retries;
    relock_nxt  = relock_count;
    case (state)
      PLLRST:   nxt = (cnt == RST_END) ? WAITLOCK : PLLRST;
      WAITLOCK: if (lock_s) nxt = STABLE;
                else if (cnt == LOCK_END) begin
                  retries_nxt = retries + 4'd1;
                  nxt         = (retries_nxt == MAX_R) ? FAULT : PLLRST;
                end
      STABLE:   if (!lock_s) nxt = PLLRST;
                else if (cnt == STABLE_END) begin
                  nxt         = RUN;
                  retries_nxt = '0;
                end
      RUN:      if (!lock_s) begin
                  nxt        = PLLRST;
                  relock_nxt = relock_count + {7'd0, relock_count != 8'hff};
                end
      FAULT:    if (fault_clear) begin
                  nxt         = PLLRST;
                  retries_nxt = '0;
                end
      default:  nxt = PLLRST;
    endcase
  end
  always_ff @(posedge clk_25MHz or posedge rst)
    if (rst) begin
      sync1        <= 1'b0;
      lock_s       <= 1'b0;
      state        <= PLLRST;
      cnt          <= '0;
      retries      <= '0;
      relock_count <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      sync1        <= pll_locked;
      lock_s       <= sync1;
      state        <= nxt;
      cnt          <= (nxt != state) ? '0 : cnt + 16'd1;
      retries      <= retries_nxt;
      relock_count <= relock_nxt;
      pll_rst      <= (nxt == PLLRST) || (nxt == FAULT);
      sys_rst      <= nxt != RUN;
      ready        <= nxt == RUN;
      fault        <= nxt == FAULT;
    end
endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per attempt; legal range 1..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 25000: cycles allowed for lock after pll_rst release (1 ms at 25 MHz); legal range 1..65535.
REQ-003 Parameter STABLE_CYCLES, default 256: cycles synchronized lock must stay high before release; legal range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3: consecutive lock timeouts before fault; legal range 1..15.
REQ-005 clk_25MHz  input  1  free-running reference clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; asynchronous and active-high.
REQ-007 pll_locked  input  1  PLL LOCK; asynchronous to clk_25MHz.
REQ-008 fault_clear  input  1  single-cycle request to leave FAULT.
REQ-009 pll_rst  output  1  drives PLL RST, active-high.
REQ-010 sys_rst  output  1  active-high reset to logic in PLL output domains.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 relock_count  output  8  saturating count of lock losses seen in RUN.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer; lock_s (second flop) is the only lock signal the FSM uses.
REQ-015 FSM states SHALL be PLLRST, WAITLOCK, STABLE, RUN, FAULT; one 16-bit counter shared, cleared on every state entry.
REQ-016 PLLRST: pll_rst=1, sys_rst=1; after RST_CYCLES cycles -> WAITLOCK.
REQ-017 WAITLOCK: pll_rst=0, sys_rst=1; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT with lock_s=0 -> increment retry count, then FAULT if retry count = MAX_RETRIES, else PLLRST.
REQ-018 If lock_s=1 and the timeout fire in the same cycle, the transition SHALL be to STABLE; lock wins.
REQ-019 STABLE: pll_rst=0, sys_rst=1; lock_s=0 on any cycle -> PLLRST, retry count unchanged; after STABLE_CYCLES consecutive cycles with lock_s=1 -> RUN, retry count cleared.
REQ-020 RUN: pll_rst=0, sys_rst=0, ready=1; lock_s=0 -> PLLRST in the next cycle, relock_count incremented, saturating at 255.
REQ-021 sys_rst SHALL rise in the same cycle the FSM leaves RUN: registered from next-state, so there is no cycle with ready=1 and lock_s=0 beyond the detection cycle.
REQ-022 FAULT: pll_rst=1, sys_rst=1, fault=1; fault_clear=1 -> PLLRST with retry count cleared; pll_locked is ignored in FAULT.
REQ-023 fault_clear SHALL be ignored in every state except FAULT.
REQ-024 All outputs SHALL be registered; no combinational path from pll_locked or fault_clear to any output.
REQ-025 Latency: pll_locked rising to lock_s is 2 cycles; lock_s high to ready high is STABLE_CYCLES+1 cycles.

Reset
REQ-026 While rst=1, the block SHALL hold: state=PLLRST, counter=0, retry count=0, synchronizer=0, pll_rst=1, sys_rst=1, ready=0, fault=0, relock_count=0.
REQ-027 rst asserted mid-operation in any state SHALL force REQ-026 values immediately, without waiting for a clock edge.
REQ-028 After rst deasserts, the sequence SHALL restart from PLLRST with a full RST_CYCLES count.

Verification
REQ-029 Nominal lock, defaults: rst released; pll_locked rises 100 cycles after pll_rst falls and stays high. Required: pll_rst high exactly 16 cycles; ready and sys_rst=0 exactly 2+256+1 cycles after pll_locked rises.
REQ-030 Timeout and fault: pll_locked held 0, LOCK_TIMEOUT=50. Required: three PLLRST/WAITLOCK attempts, then fault=1 with pll_rst=1; fault_clear pulse -> new 16-cycle pll_rst attempt, fault=0.
REQ-031 Lock glitch in STABLE: pll_locked drops for 1 cycle at cycle 100 of STABLE. Required: return to PLLRST, ready never asserted, retry count unchanged, so 3 more timeouts are needed to reach FAULT.
REQ-032 Loss in RUN: from RUN, pll_locked falls. Required: within 3 cycles sys_rst=1, ready=0, pll_rst=1 for 16 cycles, relock_count increments 0->1; repeat 300 losses -> relock_count stays at 255.
REQ-033 Simultaneous events: lock_s rises on the exact timeout cycle -> STABLE, not PLLRST. Asynchronous rst pulse in RUN -> outputs reach reset values before the next clock edge, and relock_count returns to 0.
REQ-034 Synchronizer: a pll_locked pulse of 1 cycle width aligned to the clock SHALL appear on lock_s for 1 cycle after a 2-cycle delay; a fault_clear pulse in RUN has no effect.
